coin_acceptor: RTL and testbench

- Front-end stage directly upstream of the vending machine FSM.
- Takes two raw, asynchronous coin-sensor lines (5-rupee and 10-rupee slots), then synchronises, debounces and edge-detects them.
- Queues coin events in a small FIFO and presents them on the 2-bit coin code the vending machine consumes: one code per cycle, 00 when idle.
- Rejects ambiguous or overflow insertions and flags jammed sensors.

---
 rtl/coin_pkg.sv | 15 +
 rtl/coin_debounce.sv | 57 +++++
 rtl/coin_acceptor.sv | 84 ++++++++
 tb/tb_coin_acceptor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Coin codes shared by the coin acceptor and the vending machine FSM.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_RSVD = 2'b11
  } coin_t;

  function automatic coin_t chan_code(input logic is_ten);
    return is_ten ? COIN_10 : COIN_5;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchroniser, debounce, rising-edge event
// and stuck-high (jam) detection.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic sense,
  output logic deb,
  output logic rise,
  output logic jam_hit
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int JW = $clog2(JAM_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          deb_q;
  logic [DW-1:0] deb_cnt;
  logic [JW-1:0] jam_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
      jam_cnt <= '0;
    end else begin
      sync_p0 <= sense;
      sync_p1 <= sync_p0;
      deb_q   <= deb;
      // deb only follows s after DEBOUNCE_CYCLES consecutive disagreeing samples
      if (sync_p1 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb     <= sync_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      // saturates at JAM_CYCLES so jam_hit stays asserted while the sensor is stuck
      if (!deb) begin
        jam_cnt <= '0;
      end else if (jam_cnt != JW'(JAM_CYCLES)) begin
        jam_cnt <= jam_cnt + JW'(1);
      end
    end
  end

  assign rise    = deb & ~deb_q;
  assign jam_hit = (jam_cnt == JW'(JAM_CYCLES));

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: two debounced sensor channels feeding a small coin
// event FIFO that presents one registered coin code per cycle downstream.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int JAM_CYCLES      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sense_5,
  input  logic                          sense_10,
  input  logic                          accept_ready,
  output coin_t                         coin,
  output logic                          reject,
  output logic                          jam,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic deb_5, deb_10;
  logic rise_5, rise_10;
  logic hit_5, hit_10;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_deb_5 (
    .clk(clk), .rst(rst), .sense(sense_5), .deb(deb_5), .rise(rise_5), .jam_hit(hit_5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_deb_10 (
    .clk(clk), .rst(rst), .sense(sense_10), .deb(deb_10), .rise(rise_10), .jam_hit(hit_10)
  );

  coin_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic  full, empty, pop, push, rej, one_rise;
  coin_t push_code;

  always_comb begin
    full      = (level == LW'(FIFO_DEPTH));
    empty     = (level == '0);
    pop       = accept_ready & ~empty;
    one_rise  = rise_5 ^ rise_10;
    // a full FIFO still takes a coin when the head leaves on the same edge
    push      = ~jam & one_rise & (~full | pop);
    rej       = ~jam & ((rise_5 & rise_10) | (one_rise & full & ~pop));
    push_code = chan_code(rise_10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= COIN_NONE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      coin   <= COIN_NONE;
      reject <= 1'b0;
      jam    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      coin   <= pop ? mem[rd_ptr] : COIN_NONE;
      reject <= rej;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (!deb_5 && !deb_10) jam <= 1'b0;
      else if (hit_5 || hit_10) jam <= 1'b1;
    end
  end

  assign fifo_level = level;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: vector table, hand-written corner
// sequences and randomized sensor traffic against a behavioural model.
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int J     = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense_5, sense_10, accept_ready;
  logic [1:0] coin;
  logic       reject, jam;
  logic [2:0] fifo_level;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .JAM_CYCLES(J)) dut (
    .clk(clk), .rst(rst), .sense_5(sense_5), .sense_10(sense_10),
    .accept_ready(accept_ready), .coin(coin), .reject(reject), .jam(jam),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: sensor delay line, sliding debounce window, run lengths
  int m_sq[2][$];
  int m_win[2][$];
  int m_deb[2], m_debq[2], m_run[2];
  int m_fifo[$];
  int m_coin, m_rej, m_jam;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_sq[c].delete();
      m_sq[c].push_back(0);
      m_sq[c].push_back(0);
      m_win[c].delete();
      m_deb[c] = 0; m_debq[c] = 0; m_run[c] = 0;
    end
    m_fifo.delete();
    m_coin = 0; m_rej = 0; m_jam = 0;
  endtask

  task automatic model_step();
    int raw[2], rise[2], pre_deb[2], pre_run[2];
    int pop, full, one, s, all_diff, head;
    raw[0] = int'(sense_5);
    raw[1] = int'(sense_10);
    for (int c = 0; c < 2; c++) begin
      rise[c]    = (m_deb[c] == 1 && m_debq[c] == 0) ? 1 : 0;
      pre_deb[c] = m_deb[c];
      pre_run[c] = m_run[c];
    end
    full = (m_fifo.size() == DEPTH) ? 1 : 0;
    pop  = (accept_ready && m_fifo.size() > 0) ? 1 : 0;
    m_coin = 0;
    if (pop == 1) begin
      head   = m_fifo.pop_front();
      m_coin = head;
    end
    one   = (rise[0] != rise[1]) ? 1 : 0;
    m_rej = 0;
    if (m_jam == 0) begin
      if (rise[0] == 1 && rise[1] == 1) m_rej = 1;
      else if (one == 1) begin
        if (full == 1 && pop == 0) m_rej = 1;
        else m_fifo.push_back(rise[1] == 1 ? 2 : 1);
      end
    end
    if (pre_deb[0] == 0 && pre_deb[1] == 0) m_jam = 0;
    else if (pre_run[0] >= J || pre_run[1] >= J) m_jam = 1;
    for (int c = 0; c < 2; c++) begin
      s = m_sq[c].pop_front();
      m_sq[c].push_back(raw[c]);
      m_debq[c] = m_deb[c];
      m_run[c]  = (m_deb[c] == 1) ? m_run[c] + 1 : 0;
      m_win[c].push_back(s);
      if (m_win[c].size() > D) s = m_win[c].pop_front();
      all_diff = (m_win[c].size() == D) ? 1 : 0;
      foreach (m_win[c][i]) if (m_win[c][i] == m_deb[c]) all_diff = 0;
      if (all_diff == 1) m_deb[c] = 1 - m_deb[c];
    end
  endtask

  int cnt5, cnt10, cntrej, maxlvl;

  task automatic clear_counts();
    cnt5 = 0; cnt10 = 0; cntrej = 0; maxlvl = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    #1;
    check("model_coin", int'(coin), m_coin);
    check("model_reject", int'(reject), m_rej);
    check("model_jam", int'(jam), m_jam);
    check("model_level", int'(fifo_level), m_fifo.size());
    if (coin == 2'b01) cnt5++;
    if (coin == 2'b10) cnt10++;
    if (reject) cntrej++;
    if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
  endtask

  task automatic insert(input int ten, input int hold, input int gap);
    for (int k = 0; k < hold + gap; k++) begin
      sense_5  = (ten == 0 && k < hold);
      sense_10 = (ten == 1 && k < hold);
      tick();
    end
  endtask

  typedef struct {
    int len5; int len10; int off10;
    int exp5; int exp10; int exprej;
  } vec_t;

  vec_t vecs[8];
  int   coin_at[21];
  int   hold5, hold10;

  initial begin
    vecs[0] = '{10, 0, 0, 1, 0, 0};  // plain five
    vecs[1] = '{0, 3, 0, 0, 0, 0};   // glitch shorter than debounce window
    vecs[2] = '{0, 4, 0, 0, 1, 0};   // exactly the debounce window
    vecs[3] = '{3, 0, 0, 0, 0, 0};
    vecs[4] = '{8, 8, 0, 0, 0, 1};   // simultaneous insertion
    vecs[5] = '{6, 6, 1, 1, 1, 0};   // one cycle apart: two separate events
    vecs[6] = '{6, 6, 5, 1, 1, 0};
    vecs[7] = '{0, 10, 0, 0, 1, 0};

    rst = 1'b0; sense_5 = 1'b0; sense_10 = 1'b0; accept_ready = 1'b0;
    model_reset();
    clear_counts();
    repeat (3) tick();
    rst = 1'b1;
    check("reset_coin", int'(coin), 0);
    check("reset_reject", int'(reject), 0);
    check("reset_jam", int'(jam), 0);
    check("reset_level", int'(fifo_level), 0);

    // single five-rupee coin latency
    accept_ready = 1'b1;
    tick();
    clear_counts();
    for (int k = 1; k <= 20; k++) begin
      sense_5 = (k <= 10);
      tick();
      coin_at[k] = int'(coin);
    end
    check("lat_edge7", coin_at[7], 0);
    check("lat_edge8", coin_at[8], 1);
    check("lat_edge9", coin_at[9], 0);
    check("lat_reject", cntrej, 0);
    check("lat_maxlevel", maxlvl, 1);

    // vector table
    foreach (vecs[i]) begin
      clear_counts();
      for (int cyc = 0; cyc < 40; cyc++) begin
        sense_5  = (cyc < vecs[i].len5);
        sense_10 = (cyc >= vecs[i].off10 && cyc < vecs[i].off10 + vecs[i].len10);
        tick();
      end
      check($sformatf("vec%0d_five", i), cnt5, vecs[i].exp5);
      check($sformatf("vec%0d_ten", i), cnt10, vecs[i].exp10);
      check($sformatf("vec%0d_reject", i), cntrej, vecs[i].exprej);
    end

    // FIFO fill with overflow reject, then drain
    accept_ready = 1'b0;
    clear_counts();
    insert(0, 6, 6); insert(0, 6, 6); insert(1, 6, 6); insert(0, 6, 6); insert(1, 6, 6);
    repeat (6) tick();
    check("fill_level", int'(fifo_level), 4);
    check("fill_reject", cntrej, 1);
    accept_ready = 1'b1;
    tick(); check("drain0", int'(coin), 1);
    tick(); check("drain1", int'(coin), 1);
    tick(); check("drain2", int'(coin), 2);
    tick(); check("drain3", int'(coin), 1);
    tick(); check("drain4", int'(coin), 0);
    check("drain_level", int'(fifo_level), 0);

    // jam: sense_5 stuck, ten inserted during jam is ignored
    repeat (10) tick();
    clear_counts();
    for (int k = 1; k <= 110; k++) begin
      sense_5  = (k <= 80);
      sense_10 = (k >= 72 && k <= 77);
      tick();
      if (k == 78) check("jam_set", int'(jam), 1);
    end
    check("jam_cleared", int'(jam), 0);
    check("jam_five", cnt5, 1);
    check("jam_ten", cnt10, 0);
    check("jam_reject", cntrej, 0);

    // async reset with queued coins
    accept_ready = 1'b0;
    insert(0, 6, 6); insert(1, 6, 6); insert(0, 6, 6);
    repeat (4) tick();
    check("prereset_level", int'(fifo_level), 3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_coin", int'(coin), 0);
    check("async_level", int'(fifo_level), 0);
    repeat (2) tick();
    rst = 1'b1;
    accept_ready = 1'b1;
    clear_counts();
    repeat (20) tick();
    check("no_stale_coins", cnt5 + cnt10, 0);

    // randomized traffic against the model
    hold5 = 0; hold10 = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold5 == 0) begin
        sense_5 = ~sense_5;
        hold5 = sense_5 ? (($urandom_range(0, 40) == 0) ? 75 : int'($urandom_range(1, 12)))
                        : int'($urandom_range(1, 20));
      end
      if (hold10 == 0) begin
        sense_10 = ~sense_10;
        hold10 = sense_10 ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 20));
      end
      hold5--; hold10--;
      accept_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
